// File: rtl/mux_tree_pipe.sv
// Parametrised N-to-1 multiplexer tree with one register per select level.
// Each stage uses a bubble-collapsing valid/ready handshake and carries the full select as an echo.
`timescale 1ns/1ps
module mux_tree_pipe #(
    parameter int W = 4,
    parameter int N = 8,
    localparam int LV = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [LV-1:0]   in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [LV-1:0]   out_sel
);

    logic [LV:0]   rdy;
    logic [LV-1:0] v;

    assign rdy[LV]  = out_ready;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < LV; k++) begin : lvl
        localparam int NI = N >> k;
        localparam int NO = N >> (k + 1);

        logic [NI*W-1:0] src;
        logic [LV-1:0]   src_sel;
        logic            src_v;
        logic            ld;
        logic [NO*W-1:0] mux;
        logic [NO*W-1:0] dat;
        logic [LV-1:0]   sel;
        logic            vr;

        if (k == 0) begin : g_head
            assign src     = in_data;
            assign src_sel = in_sel;
            assign src_v   = in_valid;
            assign ld      = in_valid && rdy[0];
        end else begin : g_link
            assign src     = lvl[k-1].dat;
            assign src_sel = lvl[k-1].sel;
            assign src_v   = v[k-1];
            assign ld      = rdy[k];
        end

        // Level k resolves select bit k: entry 2j on the 0 side, 2j+1 on the 1 side.
        always_comb begin
            // NOTE: assign a default before the loop so no latch can be inferred.
            mux = '0;
            for (int j = 0; j < NO; j++) begin
                mux[j*W +: W] = src_sel[k] ? src[(2*j+1)*W +: W] : src[(2*j)*W +: W];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vr  <= 1'b0;
                sel <= '0;
                dat <= '0;
            end else begin
                // NOTE: non-blocking so every stage samples its upstream's pre-edge value.
                if (rdy[k]) begin
                    vr <= src_v;
                end
                if (ld) begin
                    sel <= src_sel;
                    dat <= mux;
                end
            end
        end

        // An empty stage always accepts, so bubbles collapse even under a stalled output.
        assign rdy[k] = !vr || rdy[k+1];
        assign v[k]   = vr;
    end

    assign out_valid = v[LV-1];
    assign out_data  = lvl[LV-1].dat;
    assign out_sel   = lvl[LV-1].sel;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: default (N=8,W=4), minimal (N=2,W=1) and wide (N=16,W=12).
// Outputs are sampled 1 ns after a rising edge; a beat seen there is the one presented for the next edge.
`timescale 1ns/1ps
module tb_mux_tree_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         a_iv, a_ir, a_ov, a_or;
    logic [31:0]  a_id;
    logic [2:0]   a_is, a_os;
    logic [3:0]   a_od;

    logic         b_iv, b_ir, b_ov, b_or;
    logic [1:0]   b_id;
    logic [0:0]   b_is, b_os;
    logic [0:0]   b_od;

    logic         c_iv, c_ir, c_ov, c_or;
    logic [191:0] c_id;
    logic [3:0]   c_is, c_os;
    logic [11:0]  c_od;

    mux_tree_pipe #(.W(4), .N(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_sel(a_is),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_sel(a_os));

    mux_tree_pipe #(.W(1), .N(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_sel(b_is),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_sel(b_os));

    mux_tree_pipe #(.W(12), .N(16)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .in_sel(c_is),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_sel(c_os));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int bp_exp[5] = '{7, 6, 5, 4, 3};
    int pend[$];
    int nrecv;
    logic acc_in, acc_out;
    int pv[5] = '{1, 0, 1, 0, 1};
    int ps[5] = '{1, 0, 3, 0, 6};

    initial begin
        rst = 1'b1;
        a_iv = 0; a_or = 0; a_id = '0; a_is = '0;
        b_iv = 0; b_or = 0; b_id = '0; b_is = '0;
        c_iv = 0; c_or = 0; c_id = '0; c_is = '0;
        #12;
        check("rst_ov", a_ov, 0);
        check("rst_od", a_od, 0);
        check("rst_os", a_os, 0);
        check("rst_ir", a_ir, 1);
        @(posedge clk);
        #2 rst = 1'b0;

        // Full channel sweep: channel i carries value i, one beat per cycle.
        a_id = 32'h7654_3210;
        a_or = 1'b1;
        for (int c = 0; c < 11; c++) begin
            a_iv = (c < 8);
            a_is = 3'(c);
            tick();
            if (c >= 2 && c < 10) begin
                check("sweep_ov", a_ov, 1);
                check("sweep_od", a_od, 64'(c - 2));
                check("sweep_os", a_os, 64'(c - 2));
            end else begin
                check("sweep_idle", a_ov, 0);
            end
        end
        a_iv = 1'b0;

        // Latency: a single beat on channel 5, visible for exactly one cycle.
        a_id = 32'h76A4_3210;
        a_is = 3'd5;
        a_iv = 1'b1;
        tick();
        a_iv = 1'b0;
        check("lat_e0", a_ov, 0);
        tick();
        check("lat_e1", a_ov, 0);
        tick();
        check("lat_ov", a_ov, 1);
        check("lat_od", a_od, 4'hA);
        check("lat_os", a_os, 5);
        tick();
        check("lat_drop", a_ov, 0);

        // Backpressure: three beats fill the pipe, then the input stalls.
        a_id = 32'h7654_3210;
        a_iv = 1'b1;
        a_is = 3'd7;
        tick();
        a_is = 3'd6;
        tick();
        a_or = 1'b0;
        a_is = 3'd5;
        #1 check("bp_ir_room", a_ir, 1);
        tick();
        a_is = 3'd4;
        #1 check("bp_ir_full", a_ir, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_ir", a_ir, 0);
            check("bp_hold_ov", a_ov, 1);
            check("bp_hold_od", a_od, 7);
            check("bp_hold_os", a_os, 7);
        end
        pend = '{4, 3};
        nrecv = 0;
        a_or = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a_iv = (pend.size() > 0);
            a_is = (pend.size() > 0) ? 3'(pend[0]) : 3'd0;
            #1;
            acc_in  = a_iv && a_ir;
            acc_out = a_ov && a_or;
            if (acc_out) begin
                if (nrecv < 5) begin
                    check("bp_od", a_od, 64'(bp_exp[nrecv]));
                    check("bp_os", a_os, 64'(bp_exp[nrecv]));
                end
                nrecv++;
            end
            tick();
            if (acc_in) void'(pend.pop_front());
        end
        a_iv = 1'b0;
        check("bp_count", 64'(nrecv), 5);
        check("bp_sent", 64'(pend.size()), 0);

        // Bubbles: valid pattern 1,0,1,0,1 reappears shifted by the pipeline depth.
        for (int c = 0; c < 8; c++) begin
            a_iv = (c < 5) ? (pv[c] != 0) : 1'b0;
            a_is = (c < 5) ? 3'(ps[c]) : 3'd0;
            tick();
            if (c >= 2 && (c - 2) < 5) begin
                check("bub_ov", a_ov, 64'(pv[c-2]));
                if (pv[c-2] != 0) check("bub_od", a_od, 64'(ps[c-2]));
            end else begin
                check("bub_idle", a_ov, 0);
            end
        end
        a_iv = 1'b0;

        // Reset mid-stream with three beats in flight.
        a_or = 1'b0;
        a_iv = 1'b1;
        for (int i = 2; i < 5; i++) begin
            a_is = 3'(i);
            tick();
        end
        a_iv = 1'b0;
        check("mid_pre_ov", a_ov, 1);
        check("mid_pre_od", a_od, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ov", a_ov, 0);
        check("mid_rst_od", a_od, 0);
        check("mid_rst_os", a_os, 0);
        check("mid_rst_ir", a_ir, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        a_or = 1'b1;
        check("mid_post_ir", a_ir, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_stale", a_ov, 0);
        end

        // N=2, W=1: single level, latency of one register.
        b_id = 2'b10;
        b_or = 1'b1;
        for (int c = 0; c < 3; c++) begin
            b_iv = (c < 2);
            b_is = 1'(c);
            tick();
            if (c < 2) begin
                check("n2_ov", b_ov, 1);
                check("n2_od", b_od, 64'(c));
                check("n2_os", b_os, 64'(c));
            end else begin
                check("n2_idle", b_ov, 0);
            end
        end
        b_iv = 1'b0;

        // N=16, W=12: channel i carries 0xA00+i, four levels deep.
        for (int i = 0; i < 16; i++) c_id[i*12 +: 12] = 12'(12'hA00 + i);
        c_or = 1'b1;
        for (int c = 0; c < 20; c++) begin
            c_iv = (c < 16);
            c_is = 4'(c);
            tick();
            if (c >= 3 && c < 19) begin
                check("n16_ov", c_ov, 1);
                check("n16_od", c_od, 64'(12'hA00 + (c - 3)));
                check("n16_os", c_os, 64'(c - 3));
            end else begin
                check("n16_idle", c_ov, 0);
            end
        end
        c_iv = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
